// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M iterative multiply/divide unit:
//   XLEN_DEFAULT : default operand/result width (also the iteration count)
//   F3_*         : funct3 encodings handled by the unit
//   state_t      : controller state encoding
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_DIV = 3'b100;
    localparam logic [2:0] F3_REM = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// ---------------------------------------------------------------------------
// muldiv_datapath
// Shift registers, accumulator, trial subtractor and sign fix-up shared by
// the shift-add multiply and the restoring divide.
//   i_load      : capture operands (start of an operation)
//   i_load_div  : with i_load, capture magnitudes and signs for a divide
//   i_mul_step  : perform one multiply step
//   i_div_step  : perform one divide step
//   i_src_a/b   : rs1 / rs2 operands
//   o_mul_next  : accumulator value after the current multiply step
//   o_quot      : sign-corrected quotient
//   o_rem       : sign-corrected remainder
// Register roles:
//   MUL : r_a = multiplicand, r_b = multiplier, r_acc = product
//   DIV : r_a = dividend shifting out / quotient shifting in,
//         r_b = divisor, r_acc = partial remainder
// ---------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_load_div,
    input  logic            i_mul_step,
    input  logic            i_div_step,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic [XLEN-1:0] o_mul_next,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic            r_sign_a;
    logic            r_sign_b;

    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_diff;
    logic            w_q_bit;

    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude.
    assign w_abs_a = i_src_a[XLEN-1] ? -i_src_a : i_src_a;
    assign w_abs_b = i_src_b[XLEN-1] ? -i_src_b : i_src_b;

    assign o_mul_next = r_acc + (r_b[0] ? r_a : '0);

    // Remainder is always below the divisor, so XLEN+1 bits hold the shifted
    // value and the borrow lands in the top bit.
    assign w_rem_shift = {r_acc, r_a[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_b};
    assign w_q_bit     = ~w_diff[XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (i_load) begin
            r_a      <= i_load_div ? w_abs_a : i_src_a;
            r_b      <= i_load_div ? w_abs_b : i_src_b;
            r_acc    <= '0;
            r_sign_a <= i_load_div & i_src_a[XLEN-1];
            r_sign_b <= i_load_div & i_src_b[XLEN-1];
        end else if (i_mul_step) begin
            r_acc <= o_mul_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
        end else if (i_div_step) begin
            r_acc <= w_q_bit ? w_diff[XLEN-1:0] : {r_acc[XLEN-2:0], r_a[XLEN-1]};
            r_a   <= {r_a[XLEN-2:0], w_q_bit};
        end
    end

    assign o_quot = (r_sign_a ^ r_sign_b) ? -r_a : r_a;
    assign o_rem  = r_sign_a ? -r_acc : r_acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// EX-stage RV32M MUL/DIV/REM unit: controller FSM, step counter and pipeline
// handshake around muldiv_datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   Start      : EX instruction is a muldiv op (held while stalled)
//   funct3     : 000 MUL, 100 DIV, 110 REM; anything else returns 0
//   SrcA/SrcB  : rs1 / rs2 operands
//   Flush      : kill the in-flight operation
//   Stall      : freeze PC, IF/ID and ID/EX
//   Busy       : controller not idle
//   Valid      : Result valid this cycle
//   Result     : operation result (holds outside the valid cycle)
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Stall,
    output logic            Busy,
    output logic            Valid,
    output logic [XLEN-1:0] Result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_result;
    logic            r_valid;

    logic            w_accept;
    logic            w_is_divrem;
    logic [XLEN-1:0] w_mul_next;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;

    assign w_accept    = (r_state == ST_IDLE) && Start && !Flush;
    assign w_is_divrem = (funct3 == F3_DIV) || (funct3 == F3_REM);

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_div (w_is_divrem),
        .i_mul_step ((r_state == ST_MUL) && !Flush),
        .i_div_step ((r_state == ST_DIV) && !Flush),
        .i_src_a    (SrcA),
        .i_src_b    (SrcB),
        .o_mul_next (w_mul_next),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_f3     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (Flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Start) begin
                            r_f3    <= funct3;
                            r_count <= '0;
                            if (funct3 == F3_MUL) begin
                                r_state <= ST_MUL;
                            end else if (w_is_divrem && SrcB == '0) begin
                                r_result <= (funct3 == F3_DIV) ? '1 : SrcA;
                                r_state  <= ST_DONE;
                                r_valid  <= 1'b1;
                            end else if (w_is_divrem && SrcA == MOST_NEG && SrcB == '1) begin
                                r_result <= (funct3 == F3_DIV) ? MOST_NEG : '0;
                                r_state  <= ST_DONE;
                                r_valid  <= 1'b1;
                            end else if (w_is_divrem) begin
                                r_state <= ST_DIV;
                            end else begin
                                r_result <= '0;
                                r_state  <= ST_DONE;
                                r_valid  <= 1'b1;
                            end
                        end
                    end
                    ST_MUL: begin
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_LAST) begin
                            // Capture the accumulator including this final step.
                            r_result <= w_mul_next;
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                        end
                    end
                    ST_DIV: begin
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_LAST) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_result <= (r_f3 == F3_DIV) ? w_quot : w_rem;
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                    end
                    ST_DONE: begin
                        // Start here still belongs to the completing instruction.
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Gated by rst_n so the issuing-cycle term cannot assert Stall in reset.
    assign Stall  = rst_n && ((r_state == ST_MUL) || (r_state == ST_DIV) ||
                              (r_state == ST_FIX) || w_accept);
    assign Busy   = (r_state != ST_IDLE);
    assign Valid  = r_valid;
    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Flush = 1'b0;
    logic        Stall;
    logic        Busy;
    logic        Valid;
    logic [31:0] Result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Stall  (Stall),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M semantics from plain signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        if (f3 == F3_MUL) begin
            r = a * b;
        end else if (f3 == F3_DIV) begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = sa / sb;
        end else if (f3 == F3_REM) begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = sa % sb;
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 == F3_MUL) return 33;
        if (f3 == F3_DIV || f3 == F3_REM) begin
            if (b == 0) return 1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    // Drives one op from IDLE and records what the DUT did. Start stays high
    // through DONE and drops at the DONE cycle's falling edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit stall_ok);
        @(negedge clk);
        funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1;
        #1;
        stall_ok = (Stall === 1'b1);
        lat = -1;
        res = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (Valid === 1'b1) begin
                lat = c;
                res = Result;
                if (Stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (Stall !== 1'b1) stall_ok = 1'b0;
        end
        @(negedge clk);
        Start = 1'b0;
        $display("[TB] op f3=%b a=%h b=%h result=%h latency=%0d", f3, a, b, res, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Start = 1'b1; funct3 = F3_MUL; SrcA = 32'd7; SrcB = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        n_tests++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", Valid); end
        n_tests++; if (Result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", Result); end
        @(negedge clk);
        Start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got=%b exp=0", Busy); end
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] res;
        bit stall_ok;
        logic [31:0] exp_res;
        int exp_lat;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        issue(f3, a, b, lat, res, stall_ok);
        n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
        n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL %s_result got=%h exp=%h", name, res, exp_res); end
        n_tests++; if (!stall_ok) begin n_fail++; $display("FAIL %s_stall got=bad_profile exp=high_until_valid", name); end
    endtask

    task automatic test_mul();
        check_op("mul_7xm3", F3_MUL, 32'd7, 32'hFFFF_FFFD);
        // DUT is back in IDLE with Start low: no reissue, Result held.
        @(posedge clk); #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mul_no_reissue got=%b exp=0", Busy); end
        n_tests++; if (Result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_hold got=%h exp=ffffffeb", Result); end
    endtask

    task automatic test_div();
        check_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
        check_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
        check_op("div_100_7", F3_DIV, 32'd100, 32'd7);
        check_op("rem_100_7", F3_REM, 32'd100, 32'd7);
    endtask

    task automatic test_edge();
        check_op("div_by_zero", F3_DIV, 32'd5, 32'd0);
        check_op("rem_by_zero", F3_REM, 32'd5, 32'd0);
        check_op("div_overflow", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("rem_overflow", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("unsupported", 3'b001, 32'd9, 32'd9);
    endtask

    task automatic test_flush();
        logic [31:0] held;
        bit saw_valid;
        held = Result;
        @(negedge clk);
        funct3 = F3_DIV; SrcA = 32'd1000; SrcB = 32'd7; Start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got=%b exp=1", Busy); end
        @(negedge clk);
        Flush = 1'b1; Start = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", Busy); end
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", Stall); end
        @(negedge clk);
        Flush = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (Valid !== 1'b0 || Busy !== 1'b0) saw_valid = 1'b1;
        end
        n_tests++; if (saw_valid) begin n_fail++; $display("FAIL flush_quiet got=activity exp=idle"); end
        n_tests++; if (Result !== held) begin n_fail++; $display("FAIL flush_result_held got=%h exp=%h", Result, held); end
        $display("[TB] flush of DIV 1000/7 at cycle 10");
        check_op("mul_after_flush", F3_MUL, 32'd3, 32'd4);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        funct3 = F3_MUL; SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF1; Start = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", Busy); end
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL areset_stall got=%b exp=0", Stall); end
        n_tests++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", Valid); end
        n_tests++; if (Result !== 32'h0) begin n_fail++; $display("FAIL areset_result got=%h exp=0", Result); end
        $display("[TB] async reset during MUL at cycle 15");
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_op("div_after_reset", F3_DIV, 32'd100, 32'd7);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", F3_REM, 32'hFFFF_FF00, 32'd13);
        check_op("b2b_second", F3_MUL, 32'hDEAD_BEEF, 32'h0000_0101);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) f3 = F3_MUL;
            else if (sel <= 6) f3 = F3_DIV;
            else if (sel <= 8) f3 = F3_REM;
            else f3 = 3'($urandom_range(1, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 11);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel <= 4) b = 32'($urandom_range(1, 40)) * ((sel == 4) ? 32'hFFFF_FFFF : 32'd1);
            check_op("random", f3, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_edge();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative RV32M execution unit and its controller for the MUL/DIV/REM operations decoded by the control unit.
- Sits beside the ALU in the EX stage.
- Accepts one operation from ID/EX and holds the pipeline with Stall while it runs a 32-step shift-add multiply or restoring divide.
- Presents the result for one cycle, which EX/MEM captures.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
Start  in  1  level; EX-stage instruction is a muldiv op (held high while stalled).
funct3  in  3  op select: 000 MUL, 100 DIV, 110 REM.
SrcA  in  XLEN  rs1 operand (dividend / multiplicand).
SrcB  in  XLEN  rs2 operand (divisor / multiplier).
Flush  in  1  kill the in-flight op (branch taken / exception).
Stall  out  1  freeze PC, IF/ID and ID/EX.
Busy  out  1  FSM not in IDLE.
Valid  out  1  Result valid this cycle (DONE state).
Result  out  XLEN  operation result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Busy=0, Valid=0, Stall=0, Result=0.
  - All internal registers are cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - Start=1 and Flush=0 latches SrcA, SrcB and funct3, and clears the iteration counter.
  - MUL: next state MUL.
  - DIV/REM normal case: latch |SrcA| and |SrcB| and the sign bits; next state DIV.
  - DIV/REM by zero (SrcB=0): Result=all-ones for DIV, SrcA for REM; next state DONE.
  - DIV/REM overflow (SrcA=0x80000000, SrcB=all-ones): Result=0x80000000 for DIV, 0 for REM; next state DONE.
  - Any other funct3: Result=0; next state DONE.
- MUL, one step per cycle for XLEN cycles:
  - If multiplier LSB=1, add multiplicand to the accumulator.
  - Shift multiplicand left and multiplier right.
  - Keep the low XLEN bits only; these are sign-agnostic, so no sign correction is needed.
  - After XLEN steps: next state DONE; Result=accumulator.
- DIV, restoring, one quotient bit per cycle for XLEN cycles:
  - Shift the remainder left, bringing in the next dividend bit.
  - Trial-subtract the divisor (XLEN+1-bit subtract).
  - On non-negative: keep the difference and set the quotient bit to 1.
  - After XLEN steps: next state FIX.
- FIX, one cycle:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Result=quotient for DIV, remainder for REM; next state DONE.
- DONE, one cycle:
  - Valid=1 and Stall=0, so the pipeline advances and captures Result.
  - Next state IDLE unconditionally.
  - Start is ignored here because it still belongs to the same instruction.
- Latency, with the Start-acceptance edge as cycle 0:
  - MUL: Valid in cycle XLEN+1 (33).
  - DIV/REM: Valid in cycle XLEN+2 (34).
  - Fast paths (div-by-zero, overflow, unsupported funct3): Valid in cycle 1.
- Stall (combinational):
  - High when state is MUL, DIV or FIX.
  - Also high in IDLE when Start=1 and Flush=0, so the issuing cycle itself stalls.
  - Low in DONE.
- Busy = (state != IDLE).
- Flush:
  - In any state: next state IDLE, Valid stays 0, Result is not updated.
  - Flush wins over Start in the same cycle.
- Start is sampled only in IDLE; Start in any other state is ignored.
- Back-to-back muldiv ops: the second is accepted in the IDLE cycle after DONE.
- rst_n asserted mid-operation forces reset values immediately, with no Valid pulse.
- Result holds its last value outside DONE.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 constants F3_MUL=3'b000, F3_DIV=3'b100, F3_REM=3'b110.
  - State enum (IDLE, MUL, DIV, FIX, DONE).
  - XLEN default.
- Sub-module muldiv_datapath: shift registers, accumulator, trial subtractor and sign fix-up.
- The FSM, counter and handshake stay in the top level.

Test Plan:
- Reset: rst_n=0 with Start=1 -> Stall=0, Busy=0, Valid=0, Result=0; no activity until rst_n=1.
- MUL: SrcA=7, SrcB=0xFFFFFFFD, Start=1 -> Stall=1 for cycles 0-32; Valid=1 at cycle 33 with Result=0xFFFFFFEB; Start held through DONE does not reissue.
- DIV/REM: 0xFFFFFFF9 / 2 -> DIV Result=0xFFFFFFFD at cycle 34; REM Result=0xFFFFFFFF at cycle 34; 100/7 -> DIV 14, REM 2.
- Division edge cases, each with Valid at cycle 1 and Stall high only in cycle 0:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Flush: Flush=1 at cycle 10 of a DIV -> Busy=0 and Stall=0 from cycle 11, no Valid pulse; a following MUL 3*4 returns 12 with normal latency.
- Async reset mid-op: rst_n=0 at cycle 15 of a MUL, asynchronous to clk -> outputs reset immediately; a later op completes correctly.
